// File: rtl/prog_delay_fifo.sv
// Runtime-programmable delay line built on a circular buffer.
// {validIn,dataIn} re-emerges cur_delay clocks later. A prime event
// (first cycle out of reset, cfg_load or flush) starts a new history.
// The output stays gated until the first sample of that history reaches
// the read side, so older samples never leak through.
module prog_delay_fifo #(
  parameter int WIDTH         = 32,
  parameter int MAX_DELAY     = 64,
  parameter int DLY_W         = 7,
  parameter int DEFAULT_DELAY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [DLY_W-1:0] delay_cfg,
  input  logic             cfg_load,
  input  logic             flush,
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             primed,
  output logic [DLY_W-1:0] cur_delay
);

  localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DLY_W:0]   MAX_EXT = (DLY_W+1)'(MAX_DELAY);
  localparam logic [DLY_W-1:0] MAX_D   = DLY_W'(MAX_DELAY);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_DELAY - 1);

  logic [WIDTH:0]     mem [MAX_DELAY];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdIdx;
  logic [WIDTH:0]     rdWord;
  logic [DLY_W-1:0]   curDelayQ;
  logic [DLY_W-1:0]   cfgClamped;
  logic [DLY_W-1:0]   nextDelay;
  logic [DLY_W-1:0]   primeCnt;
  logic               started;
  logic               primeEvent;
  logic               gateOut;
  logic [DLY_W:0]     rdSum;

  assign cur_delay = curDelayQ;

  // Clamp the requested delay into the legal 1..MAX_DELAY range.
  always_comb begin
    cfgClamped = delay_cfg;
    if (delay_cfg == '0) begin
      cfgClamped = DLY_W'(1);
    end else if (delay_cfg > MAX_D) begin
      cfgClamped = MAX_D;
    end
  end

  // Event detection, delay selection and output gate.
  always_comb begin
    primeEvent = !started || cfg_load || flush;
    nextDelay  = cfg_load ? cfgClamped : curDelayQ;
    // The countdown hitting zero means the event sample is being read now;
    // a fresh event on this edge overrides that.
    gateOut    = !primeEvent && (primeCnt == '0);
  end

  // Read index = (wrPtr - D) mod MAX_DELAY; with D = MAX_DELAY this is the
  // slot being overwritten, which works because the read uses the old contents.
  always_comb begin
    rdSum = (DLY_W+1)'(wrPtr) + MAX_EXT - {1'b0, curDelayQ};
    if (rdSum >= MAX_EXT) begin
      rdSum = rdSum - MAX_EXT;
    end
    rdIdx  = rdSum[PTR_W-1:0];
    rdWord = mem[rdIdx];
  end

  // Sample storage; contents need no reset because the gate hides them.
  always_ff @(posedge clock) begin
    mem[wrPtr] <= {validIn, dataIn};
  end

  // Pointer, delay register, priming countdown and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      started   <= 1'b0;
      curDelayQ <= DLY_W'(DEFAULT_DELAY);
      primeCnt  <= '0;
      wrPtr     <= '0;
      validOut  <= 1'b0;
      dataOut   <= '0;
      primed    <= 1'b0;
    end else begin
      started   <= 1'b1;
      curDelayQ <= nextDelay;
      wrPtr     <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
      if (primeEvent) begin
        primeCnt <= nextDelay - 1'b1;
      end else if (primeCnt != '0) begin
        primeCnt <= primeCnt - 1'b1;
      end
      primed   <= gateOut;
      validOut <= gateOut && rdWord[WIDTH];
      dataOut  <= gateOut ? rdWord[WIDTH-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_prog_delay_fifo.sv
// Randomized bench for prog_delay_fifo against a history-queue model.
module tb_prog_delay_fifo;

  localparam int WIDTH = 32;
  localparam int MAXD  = 64;
  localparam int DLY_W = 7;
  localparam int DEFD  = 3;

  logic             clock = 1'b0;
  logic             rstN;
  logic             validIn;
  logic [WIDTH-1:0] dataIn;
  logic [DLY_W-1:0] delayCfg;
  logic             cfgLoad;
  logic             flush;
  logic             validOut;
  logic [WIDTH-1:0] dataOut;
  logic             primed;
  logic [DLY_W-1:0] curDelay;

  int nTests = 0;
  int nFails = 0;

  // Model: every sample since the last prime event, newest at the back.
  logic [WIDTH:0] hist[$];
  int             mD = DEFD;
  bit             mStarted = 0;

  prog_delay_fifo #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .DLY_W(DLY_W), .DEFAULT_DELAY(DEFD)) dut (
    .clock(clock), .reset(rstN), .validIn(validIn), .dataIn(dataIn),
    .delay_cfg(delayCfg), .cfg_load(cfgLoad), .flush(flush),
    .validOut(validOut), .dataOut(dataOut), .primed(primed), .cur_delay(curDelay)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampD(input int c);
    if (c == 0) return 1;
    if (c > MAXD) return MAXD;
    return c;
  endfunction

  task automatic modelReset();
    hist.delete();
    mD = DEFD;
    mStarted = 0;
  endtask

  // One clock: update model with the inputs in force at the edge, then compare.
  task automatic step();
    logic [WIDTH:0] e;
    bit             ep;
    @(posedge clock);
    if (rstN) begin
      if (!mStarted || cfgLoad || flush) begin
        hist.delete();
        if (cfgLoad) mD = clampD(int'(delayCfg));
      end
      mStarted = 1;
      hist.push_back({validIn, dataIn});
      if (hist.size() > MAXD + 1) void'(hist.pop_front());
    end
    #1;
    e  = '0;
    ep = 0;
    if (hist.size() > mD) begin
      e  = hist[hist.size() - 1 - mD];
      ep = 1;
    end
    chk("validOut", 64'(validOut), 64'(e[WIDTH]));
    chk("dataOut", 64'(dataOut), 64'(e[WIDTH-1:0]));
    chk("primed", 64'(primed), 64'(ep));
    chk("cur_delay", 64'(curDelay), 64'(mD));
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic cl,
                       input logic fl, input logic [DLY_W-1:0] c);
    validIn  = v;
    dataIn   = d;
    cfgLoad  = cl;
    flush    = fl;
    delayCfg = c;
    step();
    cfgLoad  = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    int edges;
    bit seen;
    rstN = 1'b0; validIn = 1'b0; dataIn = '0; delayCfg = '0; cfgLoad = 1'b0; flush = 1'b0;
    modelReset();
    #12;
    chk("rst_validOut", 64'(validOut), 64'd0);
    chk("rst_dataOut", 64'(dataOut), 64'd0);
    chk("rst_primed", 64'(primed), 64'd0);
    chk("rst_cur_delay", 64'(curDelay), 64'(DEFD));

    // Counting stream out of reset: first valid is sample 0, DEFD edges after the first edge.
    rstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0, '0);
      if (primed && !seen) begin
        seen = 1;
        chk("t1_first_edge", 64'(i + 1), 64'(DEFD + 1));
        chk("t1_first_data", 64'(dataOut), 64'd0);
      end
    end
    chk("t1_primed_seen", 64'(seen), 64'd1);

    // Maximum delay across several wraps with random valid.
    drive(1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 7'd64);
    for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)), WIDTH'(i), 1'b0, 1'b0, '0);

    // Shrinking the delay mid-stream must not expose older samples.
    drive(1'b1, 32'd1000, 1'b1, 1'b0, 7'd5);
    for (int i = 0; i < 10; i++) drive(1'b1, WIDTH'(2000 + i), 1'b0, 1'b0, '0);
    drive(1'b1, 32'hA5, 1'b1, 1'b0, 7'd2);
    drive(1'b1, 32'd3000, 1'b0, 1'b0, '0);
    chk("t3_gap_valid", 64'(validOut), 64'd0);
    drive(1'b1, 32'd3001, 1'b0, 1'b0, '0);
    chk("t3_valid", 64'(validOut), 64'd1);
    chk("t3_data", 64'(dataOut), 64'hA5);

    // Clamping.
    drive(1'b1, 32'd1, 1'b1, 1'b0, 7'd0);
    chk("t4_clamp_lo", 64'(curDelay), 64'd1);
    drive(1'b1, 32'd2, 1'b1, 1'b0, 7'd100);
    chk("t4_clamp_hi", 64'(curDelay), 64'd64);

    // flush+cfg_load together, then a flush before priming completes.
    drive(1'b1, 32'd10, 1'b1, 1'b1, 7'd4);
    drive(1'b1, 32'd11, 1'b0, 1'b0, '0);
    drive(1'b1, 32'd12, 1'b0, 1'b0, '0);
    drive(1'b1, 32'd13, 1'b0, 1'b1, '0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, WIDTH'(14 + k), 1'b0, 1'b0, '0);
      chk("t5_primed", 64'(primed), 64'(k == 4));
    end
    chk("t5_data", 64'(dataOut), 64'd13);

    // Asynchronous reset between edges.
    for (int i = 0; i < 8; i++) drive(1'b1, WIDTH'(500 + i), 1'b0, 1'b0, '0);
    #2;
    rstN = 1'b0;
    modelReset();
    #1;
    chk("t6_validOut", 64'(validOut), 64'd0);
    chk("t6_dataOut", 64'(dataOut), 64'd0);
    chk("t6_primed", 64'(primed), 64'd0);
    chk("t6_cur_delay", 64'(curDelay), 64'(DEFD));
    drive(1'b1, 32'd77, 1'b0, 1'b0, '0);
    #2;
    rstN = 1'b1;
    edges = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0, '0);
      edges++;
      if (primed && !seen) begin
        seen = 1;
        chk("t6_first_edge", 64'(edges), 64'(DEFD + 1));
        chk("t6_first_data", 64'(dataOut), 64'd0);
      end
    end

    // Random mix of events, delays and data.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
            DLY_W'($urandom_range(0, 100)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
